// File: rtl/pretrig_capture_buffer.sv
// Single-clock multi-channel capture buffer with a programmable pre-trigger depth.
// After arm, samples are written continuously into a circular memory. A qualified
// trigger freezes the most recent pre-trigger samples, a fixed post-trigger count is
// then recorded, and the capture is read out in chronological order.
module pretrig_capture_buffer #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic [ADDR_WIDTH:0]          number_samples,
    input  logic [ADDR_WIDTH:0]          pre_samples,
    input  logic [NUM_CH*DATA_WIDTH-1:0] din,
    input  logic                         din_ce,
    input  logic                         trigger,
    input  logic                         rd_en,
    output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
    output logic                         rd_valid,
    output logic                         armed,
    output logic                         capture_done,
    output logic                         rd_done,
    output logic [ADDR_WIDTH:0]          pre_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned WORD_W = NUM_CH * DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, FILL, POST, DONE} state_t;

    state_t state_q, state_d;

    logic [WORD_W-1:0]     mem [DEPTH];

    logic [ADDR_WIDTH:0]   pre_eff_q;
    logic [ADDR_WIDTH:0]   post_len_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH:0]   fill_cnt_q;
    logic [ADDR_WIDTH:0]   post_cnt_q;
    logic [ADDR_WIDTH-1:0] trig_addr_q;
    logic [ADDR_WIDTH:0]   pre_count_q;
    logic [ADDR_WIDTH:0]   rd_cnt_q;
    logic [WORD_W-1:0]     rd_data_q;
    logic                  rd_valid_q;
    logic                  rd_done_q;

    logic [ADDR_WIDTH:0]   ns_clamp;
    logic [ADDR_WIDTH:0]   pre_clamp;
    logic [ADDR_WIDTH:0]   total_words;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_fire;
    logic                  trig_fire;
    logic                  post_last;
    logic                  rd_fire;

    // Effective configuration derived from the raw config inputs (used only on arm)
    always_comb begin
        ns_clamp = number_samples;
        if (ns_clamp == '0) begin
            ns_clamp = CNT_ONE;
        end
        if (ns_clamp > DEPTH_CNT) begin
            ns_clamp = DEPTH_CNT;
        end
        pre_clamp = pre_samples;
        if (pre_clamp > ns_clamp - CNT_ONE) begin
            pre_clamp = ns_clamp - CNT_ONE;
        end
    end

    // arm pre-empts every other event in the cycle it is asserted
    assign wr_fire     = din_ce && !arm && (state_q == FILL || state_q == POST);
    assign trig_fire   = (state_q == FILL) && din_ce && trigger && !arm;
    assign post_last   = (state_q == POST) && din_ce && !arm && (post_cnt_q + CNT_ONE == post_len_q);
    assign total_words = pre_count_q + post_len_q;
    assign rd_fire     = (state_q == DONE) && rd_en && !arm && (rd_cnt_q != total_words);
    // oldest retained pre-trigger sample sits pre_count entries before the trigger sample
    assign rd_addr     = trig_addr_q - pre_count_q[ADDR_WIDTH-1:0] + rd_cnt_q[ADDR_WIDTH-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (trig_fire) begin
                        state_d = (post_len_q == CNT_ONE) ? DONE : POST;
                    end
                end
                POST: begin
                    if (post_last) begin
                        state_d = DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        armed        = (state_q == FILL);
        capture_done = (state_q == DONE);
    end

    // Sample memory (no reset: contents are only meaningful after a capture)
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Capture counters, trigger bookkeeping and registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_eff_q   <= '0;
            post_len_q  <= '0;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            pre_count_q <= '0;
            rd_cnt_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_done_q   <= 1'b0;
        end else if (arm) begin
            pre_eff_q   <= pre_clamp;
            post_len_q  <= ns_clamp - pre_clamp;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            pre_count_q <= '0;
            rd_cnt_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (state_q == FILL && din_ce) begin
                if (fill_cnt_q < pre_eff_q) begin
                    fill_cnt_q <= fill_cnt_q + CNT_ONE;
                end
                if (trigger) begin
                    trig_addr_q <= wr_ptr_q;
                    pre_count_q <= fill_cnt_q;
                    post_cnt_q  <= CNT_ONE;
                end
            end
            if (state_q == POST && din_ce) begin
                post_cnt_q <= post_cnt_q + CNT_ONE;
            end
            if (rd_fire) begin
                rd_data_q  <= mem[rd_addr];
                rd_valid_q <= 1'b1;
                rd_cnt_q   <= rd_cnt_q + CNT_ONE;
                if (rd_cnt_q + CNT_ONE == total_words) begin
                    rd_done_q <= 1'b1;
                end
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_done   = rd_done_q;
    assign pre_count = pre_count_q;

endmodule

// File: tb/tb_pretrig_capture_buffer.sv
// Self-checking bench for pretrig_capture_buffer: directed scenarios plus random
// traffic, compared against a queue-based model of the capture behaviour.
module tb_pretrig_capture_buffer;

    localparam int DW    = 10;
    localparam int NCH   = 2;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int W     = NCH * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          arm = 1'b0;
    logic [AW:0]   number_samples = '0;
    logic [AW:0]   pre_samples = '0;
    logic [W-1:0]  din = '0;
    logic          din_ce = 1'b0;
    logic          trigger = 1'b0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          armed;
    logic          capture_done;
    logic          rd_done;
    logic [AW:0]   pre_count;

    always #5 clk = ~clk;

    pretrig_capture_buffer #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .number_samples (number_samples),
        .pre_samples    (pre_samples),
        .din            (din),
        .din_ce         (din_ce),
        .trigger        (trigger),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .armed          (armed),
        .capture_done   (capture_done),
        .rd_done        (rd_done),
        .pre_count      (pre_count)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_FILL, M_POST, M_DONE} mode_t;
    mode_t        m_mode;
    logic [W-1:0] hist[$];
    logic [W-1:0] expq[$];
    int           ns_e, pre_e, post_e, m_pre, rd_idx;
    logic         m_rdv, m_rdone;
    logic [W-1:0] m_rdd;

    function automatic logic [W-1:0] ramp(int k);
        logic [DW-1:0] v;
        v = DW'(k);
        return {v, v};
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        hist.delete();
        expq.delete();
        m_pre  = 0;
        m_rdv  = 1'b0;
        m_rdone = 1'b0;
        m_rdd  = '0;
        rd_idx = 0;
    endtask

    // Advance the model by one clock edge using the inputs presented at that edge
    task automatic model_step();
        m_rdv = 1'b0;
        if (arm) begin
            ns_e = int'(number_samples);
            if (ns_e < 1) ns_e = 1;
            if (ns_e > DEPTH) ns_e = DEPTH;
            pre_e = int'(pre_samples);
            if (pre_e > ns_e - 1) pre_e = ns_e - 1;
            post_e = ns_e - pre_e;
            hist.delete();
            expq.delete();
            m_pre   = 0;
            m_rdone = 1'b0;
            rd_idx  = 0;
            m_mode  = M_FILL;
        end else begin
            case (m_mode)
                M_FILL: if (din_ce) begin
                    if (trigger) begin
                        m_pre = (hist.size() < pre_e) ? hist.size() : pre_e;
                        for (int i = hist.size() - m_pre; i < hist.size(); i++)
                            expq.push_back(hist[i]);
                        expq.push_back(din);
                        m_mode = (post_e == 1) ? M_DONE : M_POST;
                    end else begin
                        hist.push_back(din);
                        if (hist.size() > DEPTH) void'(hist.pop_front());
                    end
                end
                M_POST: if (din_ce) begin
                    expq.push_back(din);
                    if (expq.size() == m_pre + post_e) m_mode = M_DONE;
                end
                M_DONE: if (rd_en && rd_idx < expq.size()) begin
                    m_rdv = 1'b1;
                    m_rdd = expq[rd_idx];
                    rd_idx++;
                    if (rd_idx == expq.size()) m_rdone = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check_eq("armed",        32'(armed),        32'(m_mode == M_FILL));
        check_eq("capture_done", 32'(capture_done), 32'(m_mode == M_DONE));
        check_eq("rd_valid",     32'(rd_valid),     32'(m_rdv));
        check_eq("rd_done",      32'(rd_done),      32'(m_rdone));
        check_eq("pre_count",    32'(pre_count),    32'(m_pre));
        check_eq("rd_data",      32'(rd_data),      32'(m_rdd));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // ---------------- scenario helpers ----------------
    task automatic do_arm(int ns, int pre);
        arm = 1'b1;
        number_samples = (AW+1)'(ns);
        pre_samples    = (AW+1)'(pre);
        din_ce = 1'b0;
        trigger = 1'b0;
        rd_en = 1'b0;
        tick();
        arm = 1'b0;
    endtask

    // Ramp input until the model reports the capture complete (bounded)
    task automatic fill_ramp(int trig_k, bit gated);
        int k = 0;
        for (int c = 0; c < 200 && m_mode != M_DONE; c++) begin
            din_ce  = gated ? (c % 2 == 0) : 1'b1;
            din     = ramp(k);
            trigger = (din_ce && k == trig_k) || (gated && !din_ce);
            tick();
            if (din_ce) k++;
        end
        din_ce = 1'b0;
        trigger = 1'b0;
        check_eq("capture_reached", 32'(capture_done), 32'd1);
    endtask

    task automatic read_all(int n, int first_k);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
            check_eq("ramp_word", 32'(rd_data), 32'(ramp(first_k + i)));
        end
        check_eq("rd_done_last", 32'(rd_done), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("extra_rd_valid", 32'(rd_valid), 32'd0);
        end
        rd_en = 1'b0;
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        rst = 1'b1;
        #1;
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // nominal
        do_arm(10, 4);
        fill_ramp(20, 1'b0);
        check_eq("nom_pre_count", 32'(pre_count), 32'd4);
        read_all(10, 16);

        // early trigger
        do_arm(10, 4);
        fill_ramp(2, 1'b0);
        check_eq("early_pre_count", 32'(pre_count), 32'd2);
        read_all(8, 0);

        // clamping: ns_eff=16, pre_eff=15
        do_arm(31, 20);
        fill_ramp(30, 1'b0);
        check_eq("clamp_pre_count", 32'(pre_count), 32'd15);
        read_all(16, 15);

        // gated input, triggers on din_ce=0 cycles ignored
        do_arm(10, 4);
        fill_ramp(10, 1'b1);
        check_eq("gated_pre_count", 32'(pre_count), 32'd4);
        read_all(10, 6);

        // restart during POST
        do_arm(10, 4);
        for (int k = 0; k < 11; k++) begin
            din_ce = 1'b1;
            din = ramp(k);
            trigger = (k == 8);
            tick();
        end
        trigger = 1'b0;
        check_eq("in_post_armed", 32'(armed), 32'd0);
        do_arm(10, 4);
        check_eq("restart_armed", 32'(armed), 32'd1);
        check_eq("restart_done", 32'(capture_done), 32'd0);
        fill_ramp(5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            tick();
            check_eq("pre_rst_word", 32'(rd_data), 32'(ramp(1 + i)));
        end
        async_reset();
        for (int i = 0; i < 3; i++) tick();
        rd_en = 1'b0;

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            arm = ($urandom_range(0, 99) < 2) || (m_mode == M_IDLE);
            number_samples = (AW+1)'($urandom_range(0, 31));
            pre_samples    = (AW+1)'($urandom_range(0, 31));
            din     = W'($urandom);
            din_ce  = ($urandom_range(0, 99) < 75);
            trigger = ($urandom_range(0, 99) < 8);
            rd_en   = ($urandom_range(0, 99) < 60);
            tick();
        end
        arm = 1'b0;
        din_ce = 1'b0;
        trigger = 1'b0;
        rd_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
